// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops words from the TX FIFO and serialises them as UART frames
// (start bit, LSB-first data, optional parity, 1 or 2 stop bits). Rev 1.0
`default_nettype none

module uart_tx_fifo_reader #(
  parameter int SIZE_DATA  = 8,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_rd_en,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(SIZE_DATA + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(SIZE_DATA - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_SEL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [SIZE_DATA-1:0] shift;
  logic                 parity;
  logic                 tx;
  logic                 bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // The pop strobe is gated by reset so no word is lost in a reset cycle.
  assign o_rd_en = !i_rst && (state == IDLE) && i_tx_en && !i_fifo_empty;
  assign o_busy  = o_rd_en || (state != IDLE);
  assign o_tx    = tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      // Every state exit from a timed state coincides with bit_end, so this
      // wrap doubles as the reload on state entry.
      if (state == IDLE || state == FETCH || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (o_rd_en) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          shift  <= i_data;
          parity <= (^i_data) ^ ODD_SEL;
          tx     <= 1'b0;
          state  <= START;
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed testbench for uart_tx_fifo_reader: four instances (plain, even parity,
// odd parity, two stop bits) share one FIFO model; only the selected one sees data.
`default_nettype none

module tb_uart_tx_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] fifo_data;
  logic [3:0] rd_w, tx_w, busy_w, empty_w;

  logic [7:0] mem [0:15];
  logic [3:0] rd_ptr = '0;
  logic [3:0] wr_ptr = '0;
  int         sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign empty_w[k] = (sel != k) || (rd_ptr == wr_ptr);
    uart_tx_fifo_reader #(
      .SIZE_DATA (8),
      .BAUD_DIV  (4),
      .PARITY_EN ((k == 1 || k == 2) ? 1 : 0),
      .PARITY_ODD((k == 2) ? 1 : 0),
      .STOP_BITS ((k == 3) ? 2 : 1)
    ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_en     (tx_en),
      .i_fifo_empty(empty_w[k]),
      .i_data      (fifo_data),
      .o_rd_en     (rd_w[k]),
      .o_tx        (tx_w[k]),
      .o_busy      (busy_w[k])
    );
  end

  // FIFO model: read data valid the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rd_w[sel]) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Returns the number of negedges waited until the pop strobe, or -1 on timeout.
  task automatic wait_pop(input int k, input int limit, output int waited);
    waited = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd_w[k]) begin
        waited = i;
        break;
      end
    end
  endtask

  // Called at the negedge of the pop cycle; records one frame of nbits bit periods.
  task automatic capture(input int k, input int nbits, input int drop_at,
                         output logic [15:0] bits, output logic stable,
                         output int busy_cnt, output logic fetch_tx, output int extra_rd);
    int cyc;
    logic v;
    bits = '0;
    stable = 1'b1;
    extra_rd = 0;
    busy_cnt = busy_w[k] ? 1 : 0;
    @(negedge clk);
    fetch_tx = tx_w[k];
    busy_cnt += busy_w[k] ? 1 : 0;
    extra_rd += rd_w[k] ? 1 : 0;
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (cyc == drop_at) tx_en = 1'b0;
        cyc++;
        v = tx_w[k];
        if (c == 0) bits[b] = v;
        else if (v !== bits[b]) stable = 1'b0;
        busy_cnt += busy_w[k] ? 1 : 0;
        extra_rd += rd_w[k] ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset;
    int waited;
    sel = 0;
    tx_en = 1'b1;
    rst = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: tx=%b rd=%b busy=%b, required 1 0 0", tx_w[0], rd_w[0], busy_w[0]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_pop(0, 10, waited);
    vectors++;
    if (waited !== 0) begin
      miscompares++;
      $display("FAIL first_pop_after_reset: waited=%0d, required 0", waited);
    end
  endtask

  // Continues from the pop cycle left by test_reset.
  task automatic test_basic_frame;
    logic [15:0] bits; logic stable; int busy_cnt; logic fetch_tx; int extra_rd;
    capture(0, 10, -1, bits, stable, busy_cnt, fetch_tx, extra_rd);
    vectors++;
    if (bits[9:0] !== 10'b1101001010) begin
      miscompares++;
      $display("FAIL basic_bits: got %b, required %b", bits[9:0], 10'b1101001010);
    end
    vectors++;
    if (stable !== 1'b1 || fetch_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_timing: stable=%b fetch_tx=%b, required 1 1", stable, fetch_tx);
    end
    vectors++;
    if (busy_cnt !== 42 || extra_rd !== 0) begin
      miscompares++;
      $display("FAIL basic_busy: busy=%0d extra_rd=%0d, required 42 0", busy_cnt, extra_rd);
    end
    @(negedge clk);
    vectors++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: busy=%b tx=%b rd=%b, required 0 1 0", busy_w[0], tx_w[0], rd_w[0]);
    end
  endtask

  task automatic test_parity;
    int waited;
    logic [15:0] bits; logic stable; int busy_cnt; logic fetch_tx; int extra_rd;
    logic [10:0] exp;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      sel = k;
      push(8'hA5);
      wait_pop(k, 10, waited);
      vectors++;
      if (waited < 0) begin
        miscompares++;
        $display("FAIL parity_pop: dut %0d no pop, required pop", k);
      end
      capture(k, 11, -1, bits, stable, busy_cnt, fetch_tx, extra_rd);
      exp = (k == 1) ? 11'b10101001010 : 11'b11101001010;
      vectors++;
      if (bits[10:0] !== exp || stable !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_bits: dut %0d got %b stable=%b, required %b", k, bits[10:0], stable, exp);
      end
      vectors++;
      if (busy_cnt !== 46) begin
        miscompares++;
        $display("FAIL parity_busy: dut %0d busy=%0d, required 46", k, busy_cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    int waited;
    logic [15:0] bits; logic stable; int busy_cnt; logic fetch_tx; int extra_rd;
    @(posedge clk); #1;
    sel = 3;
    push(8'h00);
    push(8'hFF);
    wait_pop(3, 10, waited);
    capture(3, 11, -1, bits, stable, busy_cnt, fetch_tx, extra_rd);
    vectors++;
    if (bits[10:0] !== 11'b11000000000 || stable !== 1'b1 || busy_cnt !== 46) begin
      miscompares++;
      $display("FAIL b2b_first: got %b stable=%b busy=%0d, required %b 1 46", bits[10:0], stable, busy_cnt, 11'b11000000000);
    end
    @(negedge clk);
    vectors++;
    if (rd_w[3] !== 1'b1 || tx_w[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap_pop: rd=%b tx=%b, required 1 1", rd_w[3], tx_w[3]);
    end
    capture(3, 11, -1, bits, stable, busy_cnt, fetch_tx, extra_rd);
    vectors++;
    if (fetch_tx !== 1'b1 || bits[10:0] !== 11'b11111111110 || stable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: fetch_tx=%b got %b stable=%b, required 1 %b 1", fetch_tx, bits[10:0], stable, 11'b11111111110);
    end
    @(negedge clk);
    vectors++;
    if (rd_w[3] !== 1'b0 || busy_w[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: rd=%b busy=%b, required 0 0", rd_w[3], busy_w[3]);
    end
  endtask

  task automatic test_no_pop;
    int pops, lows, waited;
    logic [15:0] bits; logic stable; int busy_cnt; logic fetch_tx; int extra_rd;
    @(posedge clk); #1;
    sel = 0;
    tx_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        @(posedge clk); #1;
        tx_en = 1'b0;
        push(8'h42);
      end
      pops = 0;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        pops += rd_w[0] ? 1 : 0;
        lows += (tx_w[0] !== 1'b1) ? 1 : 0;
      end
      vectors++;
      if (pops !== 0 || lows !== 0) begin
        miscompares++;
        $display("FAIL no_pop_%0d: pops=%0d tx_low=%0d, required 0 0", pass, pops, lows);
      end
    end
    @(posedge clk); #1;
    wr_ptr = rd_ptr;
    push(8'h5A);
    push(8'h11);
    tx_en = 1'b1;
    wait_pop(0, 10, waited);
    capture(0, 10, 10, bits, stable, busy_cnt, fetch_tx, extra_rd);
    vectors++;
    if (bits[9:0] !== 10'b1010110100 || stable !== 1'b1 || busy_cnt !== 42) begin
      miscompares++;
      $display("FAIL en_drop_frame: got %b stable=%b busy=%0d, required %b 1 42", bits[9:0], stable, busy_cnt, 10'b1010110100);
    end
    pops = 0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pops += rd_w[0] ? 1 : 0;
      lows += (tx_w[0] !== 1'b1) ? 1 : 0;
    end
    vectors++;
    if (pops !== 0 || lows !== 0) begin
      miscompares++;
      $display("FAIL en_drop_idle: pops=%0d tx_low=%0d, required 0 0", pops, lows);
    end
    @(posedge clk); #1;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset_mid;
    int waited;
    logic [15:0] bits; logic stable; int busy_cnt; logic fetch_tx; int extra_rd;
    @(posedge clk); #1;
    sel = 0;
    push(8'h3C);
    push(8'h81);
    tx_en = 1'b1;
    wait_pop(0, 10, waited);
    for (int i = 0; i < 8; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: tx=%b busy=%b rd=%b, required 1 0 0", tx_w[0], busy_w[0], rd_w[0]);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_repop: rd=%b, required 1", rd_w[0]);
    end
    capture(0, 10, -1, bits, stable, busy_cnt, fetch_tx, extra_rd);
    vectors++;
    if (bits[9:0] !== 10'b1100000010 || stable !== 1'b1 || busy_cnt !== 42) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got %b stable=%b busy=%0d, required %b 1 42", bits[9:0], stable, busy_cnt, 10'b1100000010);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_no_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
